// File: rtl/muldiv_hilo.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Optional: define MULDIV_FAST_MUL_EN for a single-cycle multiply that bypasses CALC.
module muldiv_hilo (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic        div_q;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] mb;
  logic [31:0] rem;
  logic [31:0] qd;

  logic        launch;
  logic        commit;
  logic        op_div;
  logic        op_sgn;
  logic        b_zero;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic [32:0] div_diff;
  logic [63:0] mul_mag;
  logic [63:0] mul_res;
  logic [31:0] q_res;
  logic [31:0] r_res;

  assign op_div = op[1];
  assign op_sgn = ~op[0];
  assign b_zero = (b == '0);
  assign abs_a  = (op_sgn && a[31]) ? -a : a;
  assign abs_b  = (op_sgn && b[31]) ? -b : b;

  assign launch = (state == IDLE) && start && !cancel;
  assign commit = (state == DONE) && !cancel;

  assign busy  = (state != IDLE);
  assign done  = commit;
  assign stall = busy | (start & ~cancel);

  // Multiply: qd holds the multiplier and receives product low bits as it shifts right;
  // rem holds the running upper half.
  assign mul_sum = {1'b0, rem} + (qd[0] ? {1'b0, mb} : 33'd0);

  // Divide: qd holds the dividend and collects quotient bits from the right.
  assign div_sh   = {rem, qd[31]};
  assign div_diff = div_sh - {1'b0, mb};

  assign mul_mag = {rem, qd};
  assign mul_res = neg_q ? -mul_mag : mul_mag;
  assign q_res   = neg_q ? -qd : qd;
  assign r_res   = neg_r ? -rem : rem;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [63:0] fa;
  logic signed [63:0] fb;
  logic signed [63:0] fp;
  assign fa = {{32{op_sgn & a[31]}}, a};
  assign fb = {{32{op_sgn & b[31]}}, b};
  assign fp = fa * fb;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (launch) begin
`ifdef MULDIV_FAST_MUL_EN
          state_nx = op_div ? CALC : DONE;
`else
          state_nx = CALC;
`endif
        end
      end
      CALC: begin
        if (cancel)          state_nx = IDLE;
        else if (cnt == 5'd31) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      mb    <= '0;
      rem   <= '0;
      qd    <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (launch) begin
            div_q <= op_div;
            cnt   <= '0;
            rem   <= '0;
            mb    <= abs_b;
            // Divide-by-zero keeps the raw dividend and no sign fix so that hi=a, lo=all ones.
            if (op_div && b_zero) begin
              qd    <= a;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              qd    <= abs_a;
              neg_q <= op_sgn & (a[31] ^ b[31]);
              neg_r <= op_sgn & a[31] & op_div;
            end
`ifdef MULDIV_FAST_MUL_EN
            if (!op_div) begin
              rem   <= fp[63:32];
              qd    <= fp[31:0];
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end
`endif
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          if (div_q) begin
            rem <= div_diff[32] ? div_sh[31:0] : div_diff[31:0];
            qd  <= {qd[30:0], ~div_diff[32]};
          end else begin
            rem <= mul_sum[32:1];
            qd  <= {mul_sum[0], qd[31:1]};
          end
        end
        DONE: begin
          if (commit) begin
            if (div_q) begin
              hi <= r_res;
              lo <= q_res;
            end else begin
              {hi, lo} <= mul_res;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: spec vectors, cancel/reset/MTHI corner cases, random ops.
module tb_muldiv_hilo;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb[$];

  muldiv_hilo dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] o);
`ifdef MULDIV_FAST_MUL_EN
    return o[1] ? 33 : 1;
`else
    return 33;
`endif
  endfunction

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb);
    logic signed [63:0] sa, sbv;
    int ia, ib;
    case (o)
      2'd0: begin
        sa  = {{32{xa[31]}}, xa};
        sbv = {{32{xb[31]}}, xb};
        return sa * sbv;
      end
      2'd1: return {32'd0, xa} * {32'd0, xb};
      2'd2: begin
        if (xb == 32'd0) return {xa, 32'hFFFF_FFFF};
        if (xa == 32'h8000_0000 && xb == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        ia = xa;
        ib = xb;
        return {32'(ia % ib), 32'(ia / ib)};
      end
      default: begin
        if (xb == 32'd0) return {xa, 32'hFFFF_FFFF};
        return {xa % xb, xa / xb};
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [63:0] exp, input bit mt);
    int n;
    bit st_ok;
    sb.push_back(exp);
    @(negedge clk);
    op = o; a = xa; b = xb; start = 1'b1;
    if (mt) begin
      hi_we = 1'b1;
      wdata = 32'hDEAD_BEEF;
    end
    #1 check_eq("stall_c0", 64'(stall), 64'd1);
    @(posedge clk);
    #1 start = 1'b0; hi_we = 1'b0;
    if (mt) check_eq("mthi_with_start", 64'(hi), 64'hDEAD_BEEF);
    n = 1;
    st_ok = 1'b1;
    while (!done && n < 60) begin
      if (!stall) st_ok = 1'b0;
      @(posedge clk);
      #1 n++;
    end
    check_eq("latency", 64'(n), 64'(lat_of(o)));
    check_eq("stall_run", 64'(st_ok & stall), 64'd1);
    @(posedge clk);
    #1 check_eq("hilo", {hi, lo}, sb.pop_front());
    check_eq("idle_flags", 64'({busy, done, stall}), 64'd0);
  endtask

  initial begin
    int n;
    bit seen;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 check_eq("rst_hilo", {hi, lo}, 64'd0);
    check_eq("rst_flags", 64'({busy, done}), 64'd0);
    @(negedge clk) rst = 1'b0;

    run_op(2'd3, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0);
    run_op(2'd3, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1'b0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1'b0);
    run_op(2'd0, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'd2, {32'd1, 32'hFFFF_FFFE}, 1'b0);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    run_op(2'd2, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b1);

    // MTHI/MTLO preset, then cancel mid-CALC
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234;
    @(posedge clk);
    #1 hi_we = 1'b0; lo_we = 1'b0;
    check_eq("mt_preset", {hi, lo}, {32'h1234, 32'h1234});
    @(negedge clk);
    op = 2'd3; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 1; seen = 1'b0;
    while (n < 10) begin
      @(posedge clk);
      #1 n++;
      seen |= done;
    end
    cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    check_eq("cancel_idle", 64'(busy), 64'd0);
    repeat (30) begin
      @(posedge clk);
      #1 seen |= done;
    end
    check_eq("cancel_no_done", 64'(seen), 64'd0);
    check_eq("cancel_hilo", {hi, lo}, {32'h1234, 32'h1234});

    // cancel in the DONE cycle suppresses done and the write
    @(negedge clk);
    op = 2'd2; a = 32'd50; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    while (!done && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    check_eq("done_cancel_lat", 64'(n), 64'd33);
    cancel = 1'b1;
    #1 check_eq("done_cancel_low", 64'(done), 64'd0);
    @(posedge clk);
    #1 cancel = 1'b0;
    check_eq("done_cancel_busy", 64'(busy), 64'd0);
    check_eq("done_cancel_hilo", {hi, lo}, {32'h1234, 32'h1234});

    // start & cancel together in IDLE launches nothing
    @(negedge clk);
    start = 1'b1; cancel = 1'b1;
    #1 check_eq("stcan_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1 start = 1'b0; cancel = 1'b0;
    check_eq("stcan_busy", 64'(busy), 64'd0);

    // hi_we while busy is ignored; the op then completes normally
    sb.push_back({32'd1, 32'd4});
    @(negedge clk);
    op = 2'd3; a = 32'd9; b = 32'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 hi_we = 1'b1; wdata = 32'hAAAA_5555;
    @(posedge clk);
    #1 hi_we = 1'b0;
    check_eq("mthi_busy", 64'(hi), 64'h1234);
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    @(posedge clk);
    #1 check_eq("busy_mt_result", {hi, lo}, sb.pop_front());

    // async reset mid-DIV
    @(negedge clk);
    op = 2'd2; a = 32'hFFFF_FF9C; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_eq("rst_mid_flags", 64'({busy, done}), 64'd0);
    check_eq("rst_mid_hilo", {hi, lo}, 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check_eq("rst_after", 64'(busy), 64'd0);

    for (int i = 0; i < 10; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i % 2) != 0 ? 32'($urandom_range(1, 20)) : $urandom);
      run_op(ro, ra, rb, model(ro, ra, rb), i == 5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
